// File: rtl/proc_mem_responder.sv
// Dual-port word memory responder: one fetch read port and one data read/write port,
// each with a fixed-latency val/rdy response, plus a test-loader write port and sticky error flag.

module proc_mem_responder_port #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_val,
   output logic        req_rdy,
   output logic        resp_val,
   input  logic        resp_rdy,
   input  logic [31:0] rd_word,
   output logic [31:0] resp_data,
   output logic        accept_c
);
   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   assign accept_c = req_val && req_rdy;

   // State, counter and registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_rdy   <= 1'b1;
         resp_val  <= 1'b0;
         resp_data <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         req_rdy  <= (state_nx == ST_IDLE);
         resp_val <= (state_nx == ST_RESP);
         if (accept_c) begin
            resp_data <= rd_word;
         end
      end
   end

   // Next-state: IDLE -> (WAIT) -> RESP -> IDLE
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
               cnt_nx   = CNT_INIT;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_nx = ST_RESP;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (resp_rdy) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end
endmodule

module proc_mem_responder #(
   parameter int unsigned NWORDS  = 256,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemreq_val,
   output logic        imemreq_rdy,
   input  logic [31:0] imemreq_addr,
   output logic        imemresp_val,
   input  logic        imemresp_rdy,
   output logic [31:0] imemresp_data,
   input  logic        dmemreq_val,
   output logic        dmemreq_rdy,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   output logic        dmemresp_val,
   input  logic        dmemresp_rdy,
   output logic [31:0] dmemresp_rdata,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        err
);
   localparam int unsigned AW = $clog2(NWORDS);

   logic [31:0]   mem [NWORDS];
   logic [AW-1:0] i_idx, d_idx, ld_idx;
   logic          i_bad, d_bad, ld_bad;
   logic          i_acc, d_acc;
   logic [31:0]   i_rd_word, d_rd_word;

   // Misaligned or beyond the array end
   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
   endfunction

   assign i_idx  = imemreq_addr[AW+1:2];
   assign d_idx  = dmemreq_addr[AW+1:2];
   assign ld_idx = ld_addr[AW+1:2];
   assign i_bad  = bad_addr(imemreq_addr);
   assign d_bad  = bad_addr(dmemreq_addr);
   assign ld_bad = bad_addr(ld_addr);

   // Read words are taken before this edge's writes land, so same-edge reads see old data
   assign i_rd_word = i_bad ? '0 : mem[i_idx];
   assign d_rd_word = (d_bad || dmemreq_type) ? '0 : mem[d_idx];

   proc_mem_responder_port #(.LATENCY(LATENCY)) u_iport (
      .clk       (clk),
      .rst       (rst),
      .req_val   (imemreq_val),
      .req_rdy   (imemreq_rdy),
      .resp_val  (imemresp_val),
      .resp_rdy  (imemresp_rdy),
      .rd_word   (i_rd_word),
      .resp_data (imemresp_data),
      .accept_c  (i_acc)
   );

   proc_mem_responder_port #(.LATENCY(LATENCY)) u_dport (
      .clk       (clk),
      .rst       (rst),
      .req_val   (dmemreq_val),
      .req_rdy   (dmemreq_rdy),
      .resp_val  (dmemresp_val),
      .resp_rdy  (dmemresp_rdy),
      .rd_word   (d_rd_word),
      .resp_data (dmemresp_rdata),
      .accept_c  (d_acc)
   );

   // Array writes; the loader is last so it wins a same-word collision
   always_ff @(posedge clk) begin
      if (d_acc && dmemreq_type && !d_bad) begin
         mem[d_idx] <= dmemreq_wdata;
      end
      if (ld_en && !ld_bad) begin
         mem[ld_idx] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if ((i_acc && i_bad) || (d_acc && d_bad) || (ld_en && ld_bad)) begin
         err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: a LATENCY=3 instance exercising both ports and a
// LATENCY=1 instance exercising the fetch port; monitors pop expected responses per port.

module tb_proc_mem_responder;
   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   logic        ld_en;
   logic [31:0] ld_addr, ld_data;

   logic        i3_req_val, i3_req_rdy, i3_resp_val, i3_resp_rdy;
   logic [31:0] i3_addr, i3_resp_data;
   logic        d3_req_val, d3_req_rdy, d3_type, d3_resp_val, d3_resp_rdy;
   logic [31:0] d3_addr, d3_wdata, d3_rdata;
   logic        err3;

   logic        i1_req_val, i1_req_rdy, i1_resp_val, i1_resp_rdy;
   logic [31:0] i1_addr, i1_resp_data;
   logic        d1_req_rdy, d1_resp_val;
   logic [31:0] d1_rdata;
   logic        err1;

   exp_t iq3[$], dq3[$], iq1[$];
   exp_t e_i3, e_d3, e_i1;
   logic i3_seen, d3_seen, i1_seen;
   logic [31:0] i3_hold, d3_hold, i1_hold;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   proc_mem_responder #(.NWORDS(256), .LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .imemreq_val(i3_req_val), .imemreq_rdy(i3_req_rdy), .imemreq_addr(i3_addr),
      .imemresp_val(i3_resp_val), .imemresp_rdy(i3_resp_rdy), .imemresp_data(i3_resp_data),
      .dmemreq_val(d3_req_val), .dmemreq_rdy(d3_req_rdy), .dmemreq_type(d3_type),
      .dmemreq_addr(d3_addr), .dmemreq_wdata(d3_wdata),
      .dmemresp_val(d3_resp_val), .dmemresp_rdy(d3_resp_rdy), .dmemresp_rdata(d3_rdata),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err3)
   );

   proc_mem_responder #(.NWORDS(256), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .imemreq_val(i1_req_val), .imemreq_rdy(i1_req_rdy), .imemreq_addr(i1_addr),
      .imemresp_val(i1_resp_val), .imemresp_rdy(i1_resp_rdy), .imemresp_data(i1_resp_data),
      .dmemreq_val(1'b0), .dmemreq_rdy(d1_req_rdy), .dmemreq_type(1'b0),
      .dmemreq_addr(32'h0), .dmemreq_wdata(32'h0),
      .dmemresp_val(d1_resp_val), .dmemresp_rdy(1'b1), .dmemresp_rdata(d1_rdata),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err(err1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitors: first cycle of each response checks data and arrival cycle, later stall cycles check hold
   always @(negedge clk) begin
      if (!rst || !i3_resp_val) i3_seen = 1'b0;
      else if (!i3_seen) begin
         if (iq3.size() == 0) fail_now("i3 unexpected response");
         else begin
            e_i3 = iq3.pop_front();
            chk("i3 data", i3_resp_data, e_i3.data);
            chk("i3 arrival cycle", 32'(cyc), 32'(e_i3.cyc));
            i3_hold = e_i3.data;
         end
         i3_seen = 1'b1;
      end else chk("i3 hold", i3_resp_data, i3_hold);
   end

   always @(negedge clk) begin
      if (!rst || !d3_resp_val) d3_seen = 1'b0;
      else if (!d3_seen) begin
         if (dq3.size() == 0) fail_now("d3 unexpected response");
         else begin
            e_d3 = dq3.pop_front();
            chk("d3 data", d3_rdata, e_d3.data);
            chk("d3 arrival cycle", 32'(cyc), 32'(e_d3.cyc));
            d3_hold = e_d3.data;
         end
         d3_seen = 1'b1;
      end else chk("d3 hold", d3_rdata, d3_hold);
   end

   always @(negedge clk) begin
      if (!rst || !i1_resp_val) i1_seen = 1'b0;
      else if (!i1_seen) begin
         if (iq1.size() == 0) fail_now("i1 unexpected response");
         else begin
            e_i1 = iq1.pop_front();
            chk("i1 data", i1_resp_data, e_i1.data);
            chk("i1 arrival cycle", 32'(cyc), 32'(e_i1.cyc));
            i1_hold = e_i1.data;
         end
         i1_seen = 1'b1;
      end else chk("i1 hold", i1_resp_data, i1_hold);
   end

   task automatic ld(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic i3_req(input logic [31:0] a, input logic [31:0] exp);
      int   n;
      exp_t e;
      @(negedge clk);
      i3_req_val = 1'b1; i3_addr = a;
      n = 0;
      while (!i3_req_rdy && n < 100) begin @(negedge clk); n++; end
      if (!i3_req_rdy) begin fail_now("i3 request timeout"); i3_req_val = 1'b0; return; end
      e.data = exp; e.cyc = cyc + 3;
      iq3.push_back(e);
      @(negedge clk);
      i3_req_val = 1'b0;
   endtask

   task automatic i1_req(input logic [31:0] a, input logic [31:0] exp);
      int   n;
      exp_t e;
      @(negedge clk);
      i1_req_val = 1'b1; i1_addr = a;
      n = 0;
      while (!i1_req_rdy && n < 100) begin @(negedge clk); n++; end
      if (!i1_req_rdy) begin fail_now("i1 request timeout"); i1_req_val = 1'b0; return; end
      e.data = exp; e.cyc = cyc + 1;
      iq1.push_back(e);
      @(negedge clk);
      i1_req_val = 1'b0;
   endtask

   task automatic d3_req(input logic typ, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, output int acc);
      int   n;
      exp_t e;
      acc = -1;
      @(negedge clk);
      d3_req_val = 1'b1; d3_type = typ; d3_addr = a; d3_wdata = wd;
      n = 0;
      while (!d3_req_rdy && n < 100) begin @(negedge clk); n++; end
      if (!d3_req_rdy) begin fail_now("d3 request timeout"); d3_req_val = 1'b0; return; end
      acc = cyc + 1;
      e.data = exp; e.cyc = cyc + 3;
      dq3.push_back(e);
      @(negedge clk);
      d3_req_val = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((iq3.size() != 0 || dq3.size() != 0 || iq1.size() != 0 ||
              i3_resp_val || d3_resp_val || i1_resp_val) && n < 200) begin
         @(negedge clk); n++;
      end
      if (n >= 200) fail_now("drain timeout");
   endtask

   initial begin
      int   acc, rel, n;
      logic rose;
      rst = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      i3_req_val = 1'b0; i3_addr = '0; i3_resp_rdy = 1'b1;
      d3_req_val = 1'b0; d3_type = 1'b0; d3_addr = '0; d3_wdata = '0; d3_resp_rdy = 1'b1;
      i1_req_val = 1'b0; i1_addr = '0; i1_resp_rdy = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset i3 resp_val", 32'(i3_resp_val), 32'd0);
      chk("reset d3 resp_val", 32'(d3_resp_val), 32'd0);
      chk("reset d3 rdata", d3_rdata, 32'h0);
      chk("reset i3 data", i3_resp_data, 32'h0);
      chk("reset err", 32'(err3), 32'd0);
      chk("reset i1 resp_val", 32'(i1_resp_val), 32'd0);
      rst = 1'b1;
      #1;
      chk("post-reset i3 req_rdy", 32'(i3_req_rdy), 32'd1);
      chk("post-reset d3 req_rdy", 32'(d3_req_rdy), 32'd1);

      ld(32'h0, 32'h0000_0013);
      ld(32'h4, 32'hDEAD_BEEF);
      ld(32'h8, 32'h1111_1111);

      // LATENCY=1 fetch
      i1_req(32'h4, 32'hDEAD_BEEF);
      i1_req(32'h0, 32'h0000_0013);

      // LATENCY=3 fetch, then store and load-back
      i3_req(32'h4, 32'hDEAD_BEEF);
      i3_req(32'h0, 32'h0000_0013);
      d3_req(1'b1, 32'h10, 32'h1234_5678, 32'h0, acc);
      d3_req(1'b0, 32'h10, 32'h0, 32'h1234_5678, acc);
      drain();

      // Response back-pressure
      d3_resp_rdy = 1'b0;
      d3_req(1'b0, 32'h10, 32'h0, 32'h1234_5678, acc);
      n = 0;
      while (!d3_resp_val && n < 20) begin @(negedge clk); n++; end
      chk("stall resp arrives", 32'(d3_resp_val), 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("stall d3 req_rdy", 32'(d3_req_rdy), 32'd0);
         chk("stall d3 resp_val", 32'(d3_resp_val), 32'd1);
      end
      d3_resp_rdy = 1'b1;
      rel = cyc + 1;
      d3_req(1'b0, 32'h4, 32'h0, 32'hDEAD_BEEF, acc);
      chk("accept after release", 32'(acc), 32'(rel + 1));
      drain();

      // Same-edge store and fetch of one word
      fork
         d3_req(1'b1, 32'h8, 32'hAAAA_5555, 32'h0, acc);
         i3_req(32'h8, 32'h1111_1111);
      join
      i3_req(32'h8, 32'hAAAA_5555);
      d3_req(1'b0, 32'h8, 32'h0, 32'hAAAA_5555, acc);
      drain();
      chk("err clear before bad access", 32'(err3), 32'd0);

      // Bad addresses
      d3_req(1'b1, 32'h2, 32'hFFFF_FFFF, 32'h0, acc);
      drain();
      chk("err after misaligned write", 32'(err3), 32'd1);
      d3_req(1'b0, 32'h400, 32'h0, 32'h0, acc);
      i3_req(32'h400, 32'h0);
      d3_req(1'b0, 32'h0, 32'h0, 32'h0000_0013, acc);
      i3_req(32'h4, 32'hDEAD_BEEF);
      drain();
      chk("err sticky", 32'(err3), 32'd1);

      // Loader beats a same-edge store to the same word
      fork
         d3_req(1'b1, 32'hC, 32'h0BAD_F00D, 32'h0, acc);
         ld(32'hC, 32'h600D_CAFE);
      join
      d3_req(1'b0, 32'hC, 32'h0, 32'h600D_CAFE, acc);
      drain();

      // Reset while a request waits
      @(negedge clk);
      d3_req_val = 1'b1; d3_type = 1'b0; d3_addr = 32'h10;
      chk("rst-test accept rdy", 32'(d3_req_rdy), 32'd1);
      @(negedge clk);
      d3_req_val = 1'b0;
      chk("rst-test in wait rdy", 32'(d3_req_rdy), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst-test resp_val", 32'(d3_resp_val), 32'd0);
      chk("rst-test err cleared", 32'(err3), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst-test rdy after release", 32'(d3_req_rdy), 32'd1);
      rose = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (d3_resp_val) rose = 1'b1;
      end
      chk("rst-test no response", 32'(rose), 32'd0);
      d3_req(1'b0, 32'h10, 32'h0, 32'h1234_5678, acc);
      i3_req(32'h8, 32'hAAAA_5555);
      drain();
      chk("err zero after reset", 32'(err3), 32'd0);

      // Bad loader address: suppressed, flags err
      ld(32'h3, 32'h5555_5555);
      @(negedge clk);
      chk("err after bad load", 32'(err3), 32'd1);
      d3_req(1'b0, 32'h0, 32'h0, 32'h0000_0013, acc);
      drain();

      chk("queues empty", 32'(iq3.size() + dq3.size() + iq1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
